zube_wb_mailbox: RTL and testbench

ZUBE_WB_MAILBOX -- requirements
Module: zube_wb_mailbox

---
 rtl/zube_wb_mailbox.sv | 148 ++++++++++++++
 tb/tb_zube_wb_mailbox.sv | 438 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/zube_wb_mailbox.sv
// Wishbone-slave mailbox: a CPU-side register window onto a TX byte FIFO (CPU -> host)
// and an RX byte FIFO (host -> CPU), with sticky error flags and a level interrupt.
module zube_wb_mailbox #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wb_cyc_in,
  input  logic        wb_stb_in,
  input  logic        wb_we_in,
  input  logic [31:0] wb_addr_in,
  input  logic [31:0] wb_data_in,
  output logic        wb_ack_out,
  output logic [31:0] wb_data_out,
  output logic        irq_out,
  input  logic [7:0]  host_rx_data,
  input  logic        host_rx_valid,
  output logic        host_rx_ready,
  output logic [7:0]  host_tx_data,
  output logic        host_tx_valid,
  input  logic        host_tx_ready
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);

  localparam logic [1:0] REG_TX_DATA = 2'd0;
  localparam logic [1:0] REG_RX_DATA = 2'd1;
  localparam logic [1:0] REG_STATUS  = 2'd2;
  localparam logic [1:0] REG_IRQ_EN  = 2'd3;

  logic [7:0]    tx_mem [FIFO_DEPTH];
  logic [7:0]    rx_mem [FIFO_DEPTH];
  logic [AW-1:0] tx_head, tx_tail, rx_head, rx_tail;
  logic [CW-1:0] tx_count, rx_count;
  logic          tx_overflow, rx_underflow;
  logic [1:0]    irq_en;

  logic          req, wr_req, rd_req;
  logic [1:0]    reg_sel;
  logic          tx_full, tx_empty, rx_full, rx_empty;
  logic          tx_push, tx_drop, tx_pop;
  logic          rx_push, rx_pop, rx_miss;
  logic          ovf_clr, und_clr, irq_en_wr;
  logic [31:0]   status_word;
  logic [31:0]   rdata;
  logic          unused_bits;

  // A new transfer starts only outside the ack cycle, so a master holding stb
  // through the ack sees exactly one side effect and one ack per transfer.
  assign req     = wb_cyc_in & wb_stb_in & ~wb_ack_out;
  assign wr_req  = req & wb_we_in;
  assign rd_req  = req & ~wb_we_in;
  assign reg_sel = wb_addr_in[3:2];

  assign tx_full  = (tx_count == FULL_COUNT);
  assign tx_empty = (tx_count == '0);
  assign rx_full  = (rx_count == FULL_COUNT);
  assign rx_empty = (rx_count == '0);

  // Host streams use valid/ready: a byte moves on any rising edge where both
  // valid and ready are high; neither side may make valid depend on ready.
  assign host_rx_ready = ~rx_full;
  assign host_tx_valid = ~tx_empty;
  assign host_tx_data  = tx_empty ? 8'h00 : tx_mem[tx_head];

  // Fullness is judged on the pre-edge count, even if the host pops this cycle.
  assign tx_push = wr_req & (reg_sel == REG_TX_DATA) & ~tx_full;
  assign tx_drop = wr_req & (reg_sel == REG_TX_DATA) & tx_full;
  assign tx_pop  = host_tx_valid & host_tx_ready;

  assign rx_push = host_rx_valid & host_rx_ready;
  assign rx_pop  = rd_req & (reg_sel == REG_RX_DATA) & ~rx_empty;
  assign rx_miss = rd_req & (reg_sel == REG_RX_DATA) & rx_empty;

  assign ovf_clr   = wr_req & (reg_sel == REG_STATUS) & wb_data_in[2];
  assign und_clr   = wr_req & (reg_sel == REG_STATUS) & wb_data_in[3];
  assign irq_en_wr = wr_req & (reg_sel == REG_IRQ_EN);

  assign status_word = {17'b0, 3'(tx_count), 1'b0, 3'(rx_count), 4'b0,
                        rx_underflow, tx_overflow, ~tx_full, ~rx_empty};

  assign unused_bits = ^{wb_addr_in[31:4], wb_addr_in[1:0], wb_data_in[31:8]};

  always_comb begin
    rdata = 32'h0;
    case (reg_sel)
      REG_TX_DATA: rdata = 32'h0;
      REG_RX_DATA: rdata = rx_empty ? 32'h0 : {24'b0, rx_mem[rx_head]};
      REG_STATUS:  rdata = status_word;
      REG_IRQ_EN:  rdata = {30'b0, irq_en};
      default:     rdata = 32'h0;
    endcase
  end

  // Storage carries no reset: after reset the pointers make old contents unreachable.
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_tail] <= wb_data_in[7:0];
    if (rx_push) rx_mem[rx_tail] <= host_rx_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_head      <= '0;
      tx_tail      <= '0;
      tx_count     <= '0;
      rx_head      <= '0;
      rx_tail      <= '0;
      rx_count     <= '0;
      tx_overflow  <= 1'b0;
      rx_underflow <= 1'b0;
      irq_en       <= 2'b00;
      wb_ack_out   <= 1'b0;
      wb_data_out  <= 32'h0;
      irq_out      <= 1'b0;
    end else begin
      if (tx_push) tx_tail <= tx_tail + 1'b1;
      if (tx_pop)  tx_head <= tx_head + 1'b1;
      case ({tx_push, tx_pop})
        2'b10:   tx_count <= tx_count + 1'b1;
        2'b01:   tx_count <= tx_count - 1'b1;
        default: tx_count <= tx_count;
      endcase

      if (rx_push) rx_tail <= rx_tail + 1'b1;
      if (rx_pop)  rx_head <= rx_head + 1'b1;
      case ({rx_push, rx_pop})
        2'b10:   rx_count <= rx_count + 1'b1;
        2'b01:   rx_count <= rx_count - 1'b1;
        default: rx_count <= rx_count;
      endcase

      // A new error event wins over a simultaneous write-1-to-clear.
      tx_overflow  <= tx_drop | (tx_overflow & ~ovf_clr);
      rx_underflow <= rx_miss | (rx_underflow & ~und_clr);

      if (irq_en_wr) irq_en <= wb_data_in[1:0];

      wb_ack_out  <= req;
      wb_data_out <= rd_req ? rdata : 32'h0;

      // Sampled from the registered state, so the interrupt trails the state change by one cycle.
      irq_out <= (irq_en[0] & ~rx_empty) | (irq_en[1] & tx_empty);
    end
  end

endmodule

// File: tb/tb_zube_wb_mailbox.sv
// Bench for zube_wb_mailbox: directed scenarios plus randomized traffic checked
// against a queue-based reference model of the mailbox.
module tb_zube_wb_mailbox;

  localparam int D = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        wb_cyc_in, wb_stb_in, wb_we_in;
  logic [31:0] wb_addr_in, wb_data_in;
  logic        wb_ack_out;
  logic [31:0] wb_data_out;
  logic        irq_out;
  logic [7:0]  host_rx_data;
  logic        host_rx_valid, host_rx_ready;
  logic [7:0]  host_tx_data;
  logic        host_tx_valid, host_tx_ready;

  int checks = 0;
  int failures = 0;

  // Reference model state
  logic [7:0]  exp_tx_q[$];
  logic [7:0]  exp_rx_q[$];
  logic        m_ovf, m_und;
  logic [1:0]  m_en;
  logic        m_ack;
  logic [31:0] m_data;
  logic        m_irq;

  zube_wb_mailbox #(.FIFO_DEPTH(D)) dut (
    .clk(clk), .reset(reset),
    .wb_cyc_in(wb_cyc_in), .wb_stb_in(wb_stb_in), .wb_we_in(wb_we_in),
    .wb_addr_in(wb_addr_in), .wb_data_in(wb_data_in),
    .wb_ack_out(wb_ack_out), .wb_data_out(wb_data_out), .irq_out(irq_out),
    .host_rx_data(host_rx_data), .host_rx_valid(host_rx_valid), .host_rx_ready(host_rx_ready),
    .host_tx_data(host_tx_data), .host_tx_valid(host_tx_valid), .host_tx_ready(host_tx_ready)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  task automatic model_reset();
    exp_tx_q.delete();
    exp_rx_q.delete();
    m_ovf = 1'b0; m_und = 1'b0; m_en = 2'b00;
    m_ack = 1'b0; m_data = 32'h0; m_irq = 1'b0;
  endtask

  function automatic logic [31:0] m_status();
    return {17'b0, 3'(exp_tx_q.size()), 1'b0, 3'(exp_rx_q.size()), 4'b0,
            m_und, m_ovf, exp_tx_q.size() < D, exp_rx_q.size() != 0};
  endfunction

  // One rising edge of the mailbox, described as register-map behaviour on queues.
  task automatic model_edge();
    logic        req, tx_pop, rx_push, irq_n, set_ovf, set_und;
    logic [1:0]  sel;
    logic [31:0] rd;
    int          tn, rn;
    if (reset) begin
      model_reset();
      return;
    end
    req     = wb_cyc_in && wb_stb_in && !m_ack;
    sel     = wb_addr_in[3:2];
    tn      = exp_tx_q.size();
    rn      = exp_rx_q.size();
    rd      = 32'h0;
    set_ovf = 1'b0;
    set_und = 1'b0;
    irq_n   = (m_en[0] && rn != 0) || (m_en[1] && tn == 0);
    tx_pop  = (tn != 0) && host_tx_ready;
    rx_push = host_rx_valid && (rn < D);
    if (req && !wb_we_in) begin
      if (sel == 2'd1) rd = (rn != 0) ? {24'b0, exp_rx_q[0]} : 32'h0;
      if (sel == 2'd2) rd = m_status();
      if (sel == 2'd3) rd = {30'b0, m_en};
    end
    if (tx_pop) void'(exp_tx_q.pop_front());
    if (req && wb_we_in && sel == 2'd0) begin
      if (tn == D) set_ovf = 1'b1;
      else exp_tx_q.push_back(wb_data_in[7:0]);
    end
    if (req && !wb_we_in && sel == 2'd1) begin
      if (rn != 0) void'(exp_rx_q.pop_front());
      else set_und = 1'b1;
    end
    if (rx_push) exp_rx_q.push_back(host_rx_data);
    if (req && wb_we_in && sel == 2'd2) begin
      m_ovf = set_ovf || (m_ovf && !wb_data_in[2]);
      m_und = set_und || (m_und && !wb_data_in[3]);
    end else begin
      m_ovf = set_ovf || m_ovf;
      m_und = set_und || m_und;
    end
    if (req && wb_we_in && sel == 2'd3) m_en = wb_data_in[1:0];
    m_ack  = req;
    m_data = rd;
    m_irq  = irq_n;
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wb_cyc_in = 1'b0; wb_stb_in = 1'b0; wb_we_in = 1'b0;
    wb_addr_in = 32'h0; wb_data_in = 32'h0;
    host_rx_valid = 1'b0; host_rx_data = 8'h0; host_tx_ready = 1'b0;
  endtask

  // Holds stb through the ack cycle, as a Wishbone master would.
  task automatic wb_xfer(input logic we, input logic [31:0] addr, input logic [31:0] data,
                         output logic ack1, output logic [31:0] rd1,
                         output logic ack2, output logic [31:0] rd2);
    wb_cyc_in = 1'b1; wb_stb_in = 1'b1; wb_we_in = we;
    wb_addr_in = addr; wb_data_in = data;
    step();
    ack1 = wb_ack_out; rd1 = wb_data_out;
    step();
    ack2 = wb_ack_out; rd2 = wb_data_out;
    wb_cyc_in = 1'b0; wb_stb_in = 1'b0; wb_we_in = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic a1, a2;
    logic [31:0] d1, d2;
    checks++;
    if ({wb_ack_out, wb_data_out, irq_out, host_tx_valid, host_tx_data, host_rx_ready} !== {1'b0, 32'h0, 1'b0, 1'b0, 8'h0, 1'b1}) begin
      failures++;
      $display("FAIL reset_outputs got ack=%0b data=%h irq=%0b txv=%0b txd=%h rxr=%0b",
               wb_ack_out, wb_data_out, irq_out, host_tx_valid, host_tx_data, host_rx_ready);
    end
    step();
    reset = 1'b0;
    step();
    wb_xfer(1'b0, 32'h8, 32'h0, a1, d1, a2, d2);
    checks++;
    if (d1 !== 32'h0000_0002) begin
      failures++; $display("FAIL reset_status got=%h exp=%h", d1, 32'h2);
    end
    wb_xfer(1'b0, 32'hC, 32'h0, a1, d1, a2, d2);
    checks++;
    if (d1 !== 32'h0) begin
      failures++; $display("FAIL reset_irq_en got=%h exp=0", d1);
    end
  endtask

  task automatic test_tx_write();
    logic a1, a2;
    logic [31:0] d1, d2;
    wb_xfer(1'b1, 32'h0, 32'h0000_00A5, a1, d1, a2, d2);
    checks++;
    if ({a1, a2, d2} !== {1'b1, 1'b0, 32'h0}) begin
      failures++; $display("FAIL tx_write_ack got ack1=%0b ack2=%0b d2=%h exp 1 0 0", a1, a2, d2);
    end
    checks++;
    if ({host_tx_valid, host_tx_data} !== {1'b1, 8'hA5}) begin
      failures++; $display("FAIL tx_write_head got v=%0b d=%h exp v=1 d=a5", host_tx_valid, host_tx_data);
    end
    host_tx_ready = 1'b1;
    step();
    host_tx_ready = 1'b0;
    checks++;
    if (host_tx_valid !== 1'b0) begin
      failures++; $display("FAIL tx_write_pop got v=%0b exp 0", host_tx_valid);
    end
  endtask

  task automatic test_rx_fill();
    logic a1, a2;
    logic [31:0] d1, d2;
    logic [7:0] bytes [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    for (int i = 0; i < 5; i++) begin
      host_rx_valid = 1'b1; host_rx_data = bytes[i];
      step();
      if (i == 3) begin
        checks++;
        if (host_rx_ready !== 1'b0) begin
          failures++; $display("FAIL rx_fill_ready got=%0b exp 0", host_rx_ready);
        end
      end
    end
    host_rx_valid = 1'b0;
    wb_xfer(1'b0, 32'h8, 32'h0, a1, d1, a2, d2);
    checks++;
    if (d1 !== 32'h0000_0403) begin
      failures++; $display("FAIL rx_fill_status got=%h exp=%h", d1, 32'h403);
    end
    for (int i = 0; i < 4; i++) begin
      wb_xfer(1'b0, 32'h4, 32'h0, a1, d1, a2, d2);
      checks++;
      if (d1 !== {24'b0, bytes[i]}) begin
        failures++; $display("FAIL rx_read_%0d got=%h exp=%h", i, d1, {24'b0, bytes[i]});
      end
    end
    wb_xfer(1'b0, 32'h4, 32'h0, a1, d1, a2, d2);
    checks++;
    if ({a1, d1} !== {1'b1, 32'h0}) begin
      failures++; $display("FAIL rx_read_empty got ack=%0b data=%h exp ack=1 data=0", a1, d1);
    end
    wb_xfer(1'b0, 32'h8, 32'h0, a1, d1, a2, d2);
    checks++;
    if (d1 !== 32'h0000_000A) begin
      failures++; $display("FAIL rx_underflow_status got=%h exp=%h", d1, 32'hA);
    end
    wb_xfer(1'b1, 32'h8, 32'h8, a1, d1, a2, d2);
    wb_xfer(1'b0, 32'h8, 32'h0, a1, d1, a2, d2);
    checks++;
    if (d1 !== 32'h0000_0002) begin
      failures++; $display("FAIL rx_underflow_clear got=%h exp=%h", d1, 32'h2);
    end
  endtask

  task automatic test_tx_overflow();
    logic a1, a2;
    logic [31:0] d1, d2;
    host_tx_ready = 1'b0;
    for (int i = 0; i < 5; i++) wb_xfer(1'b1, 32'h0, 32'h10 + i, a1, d1, a2, d2);
    wb_xfer(1'b0, 32'h8, 32'h0, a1, d1, a2, d2);
    checks++;
    if (d1 !== 32'h0000_4004) begin
      failures++; $display("FAIL tx_overflow_status got=%h exp=%h", d1, 32'h4004);
    end
    wb_xfer(1'b1, 32'h8, 32'h4, a1, d1, a2, d2);
    wb_xfer(1'b0, 32'h8, 32'h0, a1, d1, a2, d2);
    checks++;
    if (d1 !== 32'h0000_4000) begin
      failures++; $display("FAIL tx_overflow_clear got=%h exp=%h", d1, 32'h4000);
    end
    host_tx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({host_tx_valid, host_tx_data} !== {1'b1, 8'(8'h10 + i)}) begin
        failures++; $display("FAIL tx_drain_%0d got v=%0b d=%h exp d=%h", i, host_tx_valid, host_tx_data, 8'(8'h10 + i));
      end
      step();
    end
    host_tx_ready = 1'b0;
    checks++;
    if (host_tx_valid !== 1'b0) begin
      failures++; $display("FAIL tx_drain_empty got v=%0b exp 0", host_tx_valid);
    end
  endtask

  task automatic test_irq();
    logic a1, a2;
    logic [31:0] d1, d2;
    int waited;
    wb_xfer(1'b1, 32'hC, 32'h1, a1, d1, a2, d2);
    checks++;
    if (irq_out !== 1'b0) begin
      failures++; $display("FAIL irq_idle got=%0b exp 0", irq_out);
    end
    host_rx_valid = 1'b1; host_rx_data = 8'h7E;
    step();
    host_rx_valid = 1'b0;
    waited = 0;
    while (irq_out !== 1'b1 && waited < 2) begin
      step();
      waited++;
    end
    checks++;
    if (irq_out !== 1'b1) begin
      failures++; $display("FAIL irq_rise got=%0b exp 1 within 2 cycles", irq_out);
    end
    wb_xfer(1'b0, 32'h4, 32'h0, a1, d1, a2, d2);
    checks++;
    if (d1 !== 32'h7E) begin
      failures++; $display("FAIL irq_rx_read got=%h exp=%h", d1, 32'h7E);
    end
    checks++;
    if (irq_out !== 1'b0) begin
      failures++; $display("FAIL irq_fall got=%0b exp 0", irq_out);
    end
    wb_xfer(1'b1, 32'hC, 32'h0, a1, d1, a2, d2);
  endtask

  task automatic test_cyc_drop();
    logic a1, a2;
    logic [31:0] d1, d2;
    host_tx_ready = 1'b0;
    wb_cyc_in = 1'b1; wb_stb_in = 1'b1; wb_we_in = 1'b1;
    wb_addr_in = 32'h0; wb_data_in = 32'h3C;
    step();
    wb_cyc_in = 1'b0; wb_stb_in = 1'b0;
    checks++;
    if (wb_ack_out !== 1'b1) begin
      failures++; $display("FAIL cyc_drop_after_ack got=%0b exp 1", wb_ack_out);
    end
    step();
    wb_cyc_in = 1'b0; wb_stb_in = 1'b1; wb_data_in = 32'h3D;
    step();
    wb_stb_in = 1'b0;
    checks++;
    if (wb_ack_out !== 1'b0) begin
      failures++; $display("FAIL cyc_drop_before_ack got=%0b exp 0", wb_ack_out);
    end
    wb_xfer(1'b0, 32'h8, 32'h0, a1, d1, a2, d2);
    checks++;
    if ({d1, host_tx_data} !== {32'h0000_1002, 8'h3C}) begin
      failures++; $display("FAIL cyc_drop_effects got status=%h head=%h exp 00001002 3c", d1, host_tx_data);
    end
    host_tx_ready = 1'b1;
    step();
    host_tx_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [3:0]  acks;
    logic [31:0] rd;
    wb_cyc_in = 1'b1; wb_stb_in = 1'b1; wb_we_in = 1'b1;
    wb_addr_in = 32'hC; wb_data_in = 32'hFFFF_FFF2;
    step(); acks[0] = wb_ack_out;
    wb_we_in = 1'b0;
    step(); acks[1] = wb_ack_out;
    checks++;
    if (wb_data_out !== 32'h0) begin
      failures++; $display("FAIL b2b_idle_data got=%h exp 0", wb_data_out);
    end
    step(); acks[2] = wb_ack_out; rd = wb_data_out;
    wb_cyc_in = 1'b0; wb_stb_in = 1'b0;
    step(); acks[3] = wb_ack_out;
    checks++;
    if ({acks, rd} !== {4'b0101, 32'h2}) begin
      failures++; $display("FAIL b2b got acks=%b rd=%h exp 0101 00000002", acks, rd);
    end
    wb_cyc_in = 1'b1; wb_stb_in = 1'b1; wb_we_in = 1'b1; wb_data_in = 32'h0;
    step();
    wb_cyc_in = 1'b0; wb_stb_in = 1'b0;
    step();
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      host_rx_valid = 1'($urandom_range(0, 1));
      host_rx_data  = 8'($urandom);
      host_tx_ready = ($urandom_range(0, 3) == 0);
      wb_cyc_in     = ($urandom_range(0, 3) != 0);
      wb_stb_in     = ($urandom_range(0, 3) != 0);
      wb_we_in      = 1'($urandom_range(0, 1));
      wb_addr_in    = $urandom;
      wb_data_in    = $urandom;
      step();
      checks++;
      if ({wb_ack_out, wb_data_out} !== {m_ack, m_data}) begin
        failures++;
        $display("FAIL rand_wb cyc %0d got ack=%0b data=%h exp ack=%0b data=%h", n, wb_ack_out, wb_data_out, m_ack, m_data);
      end
      checks++;
      if (irq_out !== m_irq) begin
        failures++; $display("FAIL rand_irq cyc %0d got=%0b exp=%0b", n, irq_out, m_irq);
      end
      checks++;
      if ({host_tx_valid, host_tx_data, host_rx_ready} !==
          {exp_tx_q.size() != 0, (exp_tx_q.size() != 0) ? exp_tx_q[0] : 8'h0, exp_rx_q.size() < D}) begin
        failures++;
        $display("FAIL rand_host cyc %0d got txv=%0b txd=%h rxr=%0b exp tx_n=%0d rx_n=%0d",
                 n, host_tx_valid, host_tx_data, host_rx_ready, exp_tx_q.size(), exp_rx_q.size());
      end
    end
    idle_inputs();
    step();
  endtask

  task automatic test_reset_mid();
    logic a1, a2;
    logic [31:0] d1, d2;
    wb_xfer(1'b1, 32'h8, 32'hC, a1, d1, a2, d2);
    wb_xfer(1'b1, 32'hC, 32'h0, a1, d1, a2, d2);
    host_tx_ready = 1'b1;
    host_rx_valid = 1'b0;
    for (int i = 0; i < 2 * D + 2; i++) step();
    while (exp_rx_q.size() != 0) wb_xfer(1'b0, 32'h4, 32'h0, a1, d1, a2, d2);
    host_tx_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wb_xfer(1'b1, 32'h0, 32'h21 + i, a1, d1, a2, d2);
      host_rx_valid = 1'b1; host_rx_data = 8'(8'h31 + i);
      step();
      host_rx_valid = 1'b0;
    end
    wb_xfer(1'b0, 32'h8, 32'h0, a1, d1, a2, d2);
    checks++;
    if (d1 !== 32'h0000_3303) begin
      failures++; $display("FAIL pre_reset_status got=%h exp=%h", d1, 32'h3303);
    end
    wb_cyc_in = 1'b1; wb_stb_in = 1'b1; wb_we_in = 1'b1;
    wb_addr_in = 32'h0; wb_data_in = 32'h24;
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    #1;
    checks++;
    if ({wb_ack_out, wb_data_out, irq_out, host_tx_valid, host_tx_data, host_rx_ready} !== {1'b0, 32'h0, 1'b0, 1'b0, 8'h0, 1'b1}) begin
      failures++;
      $display("FAIL reset_mid_outputs got ack=%0b data=%h irq=%0b txv=%0b txd=%h rxr=%0b",
               wb_ack_out, wb_data_out, irq_out, host_tx_valid, host_tx_data, host_rx_ready);
    end
    step();
    checks++;
    if (wb_ack_out !== 1'b0) begin
      failures++; $display("FAIL reset_mid_ack got=%0b exp 0", wb_ack_out);
    end
    wb_cyc_in = 1'b0; wb_stb_in = 1'b0;
    reset = 1'b0;
    step();
    wb_xfer(1'b0, 32'h8, 32'h0, a1, d1, a2, d2);
    checks++;
    if ({d1, host_tx_valid} !== {32'h0000_0002, 1'b0}) begin
      failures++; $display("FAIL reset_mid_status got=%h txv=%0b exp 00000002 0", d1, host_tx_valid);
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    idle_inputs();
    reset = 1'b1;
    model_reset();
    #1;
    test_reset();
    test_tx_write();
    test_rx_fill();
    test_tx_overflow();
    test_irq();
    test_cyc_drop();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
